// File: rtl/alu_res_skid_if.sv
// Handshake bundle between the ALU, the result skid buffer and the
// memory/write-back stage. The skid buffer takes the slave modport; the
// producer/consumer side (or a testbench) takes the master modport.
// Optional macro: ALU_RES_PARITY_EN adds the par_o signal.
interface alu_res_skid_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // Upstream (ALU) side
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] res_i;
    logic          zf_i;
    logic [RW-1:0] rd_i;
    logic          regwrite_i;
    logic          branch_i;

    // Downstream (memory/write-back) side
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] res_o;
    logic          zf_o;
    logic [RW-1:0] rd_o;
    logic          regwrite_o;
    logic          branch_taken_o;
`ifdef ALU_RES_PARITY_EN
    logic          par_o;
`endif

`ifdef ALU_RES_PARITY_EN
    modport slave (
        input  flush_i, valid_i, res_i, zf_i, rd_i, regwrite_i, branch_i, ready_i,
        output ready_o, valid_o, res_o, zf_o, rd_o, regwrite_o, branch_taken_o, par_o
    );
    modport master (
        output flush_i, valid_i, res_i, zf_i, rd_i, regwrite_i, branch_i, ready_i,
        input  ready_o, valid_o, res_o, zf_o, rd_o, regwrite_o, branch_taken_o, par_o
    );
`else
    modport slave (
        input  flush_i, valid_i, res_i, zf_i, rd_i, regwrite_i, branch_i, ready_i,
        output ready_o, valid_o, res_o, zf_o, rd_o, regwrite_o, branch_taken_o
    );
    modport master (
        output flush_i, valid_i, res_i, zf_i, rd_i, regwrite_i, branch_i, ready_i,
        input  ready_o, valid_o, res_o, zf_o, rd_o, regwrite_o, branch_taken_o
    );
`endif
endinterface

// File: rtl/alu_res_skid.sv
// ALU result register with a 2-entry skid buffer. Captures the ALU result,
// zero flag and write-back metadata, presents them downstream through a
// valid/ready handshake with a registered ready_o, and resolves the
// branch-taken condition on the output side.
// Optional macro: ALU_RES_PARITY_EN stores an even-parity bit per entry and
// drives it on par_o.
module alu_res_skid #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_res_skid_if.slave bus
);

    typedef struct packed {
        logic [DW-1:0] res;
        logic          zf;
        logic [RW-1:0] rd;
        logic          regwrite;
        logic          branch;
`ifdef ALU_RES_PARITY_EN
        logic          par;
`endif
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_reg;
    entry_t out_reg;
    entry_t skid_reg;
    logic   valid_reg;
    logic   ready_reg;
    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;

    // Pack the incoming ALU result into an entry; parity is taken at capture.
    always_comb begin
        in_entry          = '0;
        in_entry.res      = bus.res_i;
        in_entry.zf       = bus.zf_i;
        in_entry.rd       = bus.rd_i;
        in_entry.regwrite = bus.regwrite_i;
        in_entry.branch   = bus.branch_i;
`ifdef ALU_RES_PARITY_EN
        in_entry.par      = ^bus.res_i;
`endif
    end

    // Handshakes use only registered valid/ready, so no combinational path
    // runs from ready_i back to ready_o.
    assign in_fire  = bus.valid_i & ready_reg;
    assign out_fire = valid_reg & bus.ready_i;

    // Buffer FSM: state, slot contents and the registered valid/ready flags
    // move together; flush wins over every transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else if (bus.flush_i) begin
            state_reg <= EMPTY;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        out_reg   <= in_entry;
                        state_reg <= ONE;
                        valid_reg <= 1'b1;
                        ready_reg <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_reg <= in_entry;
                    end else if (in_fire) begin
                        skid_reg  <= in_entry;
                        state_reg <= FULL;
                        valid_reg <= 1'b1;
                        ready_reg <= 1'b0;
                    end else if (out_fire) begin
                        state_reg <= EMPTY;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                FULL: begin
                    // ready_o is low here, so nothing can arrive this cycle.
                    if (out_fire) begin
                        out_reg   <= skid_reg;
                        state_reg <= ONE;
                        valid_reg <= 1'b1;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    // Output side: the OUT slot drives the bus; write enable and branch
    // redirect are masked by valid so a stale payload has no effect.
    assign bus.ready_o        = ready_reg;
    assign bus.valid_o        = valid_reg;
    assign bus.res_o          = out_reg.res;
    assign bus.zf_o           = out_reg.zf;
    assign bus.rd_o           = out_reg.rd;
    assign bus.regwrite_o     = valid_reg & out_reg.regwrite;
    assign bus.branch_taken_o = valid_reg & out_reg.branch & out_reg.zf;
`ifdef ALU_RES_PARITY_EN
    assign bus.par_o          = out_reg.par;
`endif

endmodule

// File: tb/tb_alu_res_skid.sv
// Self-checking bench for alu_res_skid: a table of directed vectors, hand
// sequences for streaming, async reset and parity, then randomized traffic
// compared against a 2-deep FIFO reference model.
module tb_alu_res_skid;

    logic clk;
    logic rst_n;

    alu_res_skid_if #(.DW(32), .RW(5)) bus ();

    alu_res_skid #(.DW(32), .RW(5)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        zf;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
    } ent_t;

    // Reference model: the block is a FIFO of capacity two.
    ent_t q[$];

    typedef struct {
        logic        v, ri, fl;
        logic [31:0] res;
        logic        zf;
        logic [4:0]  rd;
        logic        rw, br;
        logic        e_vo, e_ro;
        logic [31:0] e_res;
        logic        e_zf;
        logic [4:0]  e_rd;
        logic        e_rw, e_bt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, " valid_o"}, 32'(bus.valid_o), 32'(q.size() > 0));
        chk({tag, " ready_o"}, 32'(bus.ready_o), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, " res_o"}, bus.res_o, q[0].res);
            chk({tag, " zf_o"}, 32'(bus.zf_o), 32'(q[0].zf));
            chk({tag, " rd_o"}, 32'(bus.rd_o), 32'(q[0].rd));
            chk({tag, " regwrite_o"}, 32'(bus.regwrite_o), 32'(q[0].rw));
            chk({tag, " branch_taken_o"}, 32'(bus.branch_taken_o), 32'(q[0].br & q[0].zf));
`ifdef ALU_RES_PARITY_EN
            chk({tag, " par_o"}, 32'(bus.par_o), 32'(^q[0].res));
`endif
        end else begin
            chk({tag, " regwrite_o idle"}, 32'(bus.regwrite_o), 32'd0);
            chk({tag, " branch_taken_o idle"}, 32'(bus.branch_taken_o), 32'd0);
        end
    endtask

    // One clock: advance the model from the driven inputs, then compare.
    task automatic cycle(input string tag);
        bit   m_ready, m_valid, in_f, out_f, fl;
        ent_t e;
        m_ready = (q.size() < 2);
        m_valid = (q.size() > 0);
        in_f    = bus.valid_i && m_ready;
        out_f   = m_valid && bus.ready_i;
        fl      = bus.flush_i;
        e       = '{res: bus.res_i, zf: bus.zf_i, rd: bus.rd_i, rw: bus.regwrite_i, br: bus.branch_i};
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) q.push_back(e);
        end
        #1;
        model_check(tag);
    endtask

    task automatic drive(input logic v, input logic ri, input logic fl, input logic [31:0] res,
                         input logic zf, input logic [4:0] rd, input logic rw, input logic br);
        bus.valid_i    = v;
        bus.ready_i    = ri;
        bus.flush_i    = fl;
        bus.res_i      = res;
        bus.zf_i       = zf;
        bus.rd_i       = rd;
        bus.regwrite_i = rw;
        bus.branch_i   = br;
    endtask

    function automatic vec_t mk(input logic v, input logic ri, input logic fl, input logic [31:0] res,
                                input logic zf, input logic [4:0] rd, input logic rw, input logic br,
                                input logic e_vo, input logic e_ro, input logic [31:0] e_res,
                                input logic e_zf, input logic [4:0] e_rd, input logic e_rw, input logic e_bt);
        vec_t t;
        t.v = v; t.ri = ri; t.fl = fl; t.res = res; t.zf = zf; t.rd = rd; t.rw = rw; t.br = br;
        t.e_vo = e_vo; t.e_ro = e_ro; t.e_res = e_res; t.e_zf = e_zf; t.e_rd = e_rd;
        t.e_rw = e_rw; t.e_bt = e_bt;
        return t;
    endfunction

    initial begin
        // Directed table: inputs for one edge, expected outputs after it.
        //            v  ri fl res     zf rd rw br   vo ro res     zf rd rw bt
        vecs[0]  = mk(1, 1, 0, 32'h5,  0, 3, 1, 0,   1, 1, 32'h5,  0, 3, 1, 0);
        vecs[1]  = mk(0, 1, 0, 32'h0,  0, 0, 0, 0,   0, 1, 32'h0,  0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 32'h11, 0, 1, 1, 0,   1, 1, 32'h11, 0, 1, 1, 0);
        vecs[3]  = mk(1, 0, 0, 32'h22, 0, 2, 1, 0,   1, 0, 32'h11, 0, 1, 1, 0);
        vecs[4]  = mk(1, 0, 0, 32'h33, 0, 4, 1, 0,   1, 0, 32'h11, 0, 1, 1, 0);
        vecs[5]  = mk(1, 1, 0, 32'h33, 0, 4, 1, 0,   1, 1, 32'h22, 0, 2, 1, 0);
        vecs[6]  = mk(1, 1, 0, 32'h33, 0, 4, 1, 0,   1, 1, 32'h33, 0, 4, 1, 0);
        vecs[7]  = mk(0, 1, 0, 32'h0,  0, 0, 0, 0,   0, 1, 32'h0,  0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 32'h0,  1, 7, 0, 1,   1, 1, 32'h0,  1, 7, 0, 1);
        vecs[9]  = mk(1, 0, 0, 32'h9,  0, 8, 0, 1,   1, 0, 32'h0,  1, 7, 0, 1);
        vecs[10] = mk(0, 1, 0, 32'h0,  0, 0, 0, 0,   1, 1, 32'h9,  0, 8, 0, 0);
        vecs[11] = mk(0, 1, 0, 32'h0,  0, 0, 0, 0,   0, 1, 32'h0,  0, 0, 0, 0);
        vecs[12] = mk(1, 0, 0, 32'h44, 0, 9, 1, 0,   1, 1, 32'h44, 0, 9, 1, 0);
        vecs[13] = mk(1, 0, 0, 32'h55, 0,10, 1, 0,   1, 0, 32'h44, 0, 9, 1, 0);
        vecs[14] = mk(1, 0, 1, 32'h66, 0,11, 1, 0,   0, 1, 32'h0,  0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,  0, 0, 0, 0,   0, 1, 32'h0,  0, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        #12;
        chk("reset valid_o", 32'(bus.valid_o), 32'd0);
        chk("reset ready_o", 32'(bus.ready_o), 32'd1);
        chk("reset res_o", bus.res_o, 32'd0);
        chk("reset zf_o", 32'(bus.zf_o), 32'd0);
        chk("reset rd_o", 32'(bus.rd_o), 32'd0);
        chk("reset regwrite_o", 32'(bus.regwrite_o), 32'd0);
        chk("reset branch_taken_o", 32'(bus.branch_taken_o), 32'd0);
`ifdef ALU_RES_PARITY_EN
        chk("reset par_o", 32'(bus.par_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven directed vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].ri, vecs[i].fl, vecs[i].res, vecs[i].zf, vecs[i].rd,
                  vecs[i].rw, vecs[i].br);
            cycle($sformatf("vec%0d model", i));
            chk($sformatf("vec%0d valid_o", i), 32'(bus.valid_o), 32'(vecs[i].e_vo));
            chk($sformatf("vec%0d ready_o", i), 32'(bus.ready_o), 32'(vecs[i].e_ro));
            chk($sformatf("vec%0d regwrite_o", i), 32'(bus.regwrite_o), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d branch_taken_o", i), 32'(bus.branch_taken_o), 32'(vecs[i].e_bt));
            if (vecs[i].e_vo) begin
                chk($sformatf("vec%0d res_o", i), bus.res_o, vecs[i].e_res);
                chk($sformatf("vec%0d zf_o", i), 32'(bus.zf_o), 32'(vecs[i].e_zf));
                chk($sformatf("vec%0d rd_o", i), 32'(bus.rd_o), 32'(vecs[i].e_rd));
            end
            $display("vec %0d: v=%0d ri=%0d fl=%0d res_i=%h -> valid_o=%0d ready_o=%0d res_o=%h",
                     i, vecs[i].v, vecs[i].ri, vecs[i].fl, vecs[i].res,
                     bus.valid_o, bus.ready_o, bus.res_o);
        end

        // Full-rate streaming: one result per cycle, one cycle latency
        for (int k = 1; k <= 8; k++) begin
            drive(1, 1, 0, 32'(k), 0, 5'(k), 1, 0);
            cycle($sformatf("stream%0d", k));
            chk($sformatf("stream%0d res_o", k), bus.res_o, 32'(k));
            chk($sformatf("stream%0d ready_o", k), 32'(bus.ready_o), 32'd1);
            $display("stream %0d: res_o=%h ready_o=%0d", k, bus.res_o, bus.ready_o);
        end
        drive(0, 1, 0, 32'h0, 0, 0, 0, 0);
        cycle("stream drain");

        // Fill to FULL, then async reset between clock edges
        drive(1, 0, 0, 32'hAA, 1, 1, 1, 1);
        cycle("pre-reset fill A");
        drive(1, 0, 0, 32'hBB, 0, 2, 1, 0);
        cycle("pre-reset fill B");
        chk("pre-reset full ready_o", 32'(bus.ready_o), 32'd0);
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("async reset valid_o", 32'(bus.valid_o), 32'd0);
        chk("async reset res_o", bus.res_o, 32'd0);
        chk("async reset ready_o", 32'(bus.ready_o), 32'd1);
        chk("async reset regwrite_o", 32'(bus.regwrite_o), 32'd0);
        chk("async reset branch_taken_o", 32'(bus.branch_taken_o), 32'd0);
        $display("async reset: valid_o=%0d ready_o=%0d res_o=%h", bus.valid_o, bus.ready_o, bus.res_o);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_check("post-reset");

`ifdef ALU_RES_PARITY_EN
        // Parity follows the OUT entry and holds under back-pressure
        drive(1, 0, 0, 32'h7, 0, 1, 1, 0);
        cycle("par push 7");
        chk("par 7", 32'(bus.par_o), 32'd1);
        drive(1, 0, 0, 32'h3, 0, 2, 1, 0);
        cycle("par push 3");
        chk("par hold", 32'(bus.par_o), 32'd1);
        drive(0, 1, 0, 32'h0, 0, 0, 0, 0);
        cycle("par pop");
        chk("par 3", 32'(bus.par_o), 32'd0);
        cycle("par drain");
        $display("parity sequence done: par_o=%0d", bus.par_o);
`endif

        // Randomized traffic against the FIFO model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0,
                  $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
            cycle($sformatf("rand%0d", n));
            $display("rand %0d: v=%0d ri=%0d fl=%0d res_i=%h -> valid_o=%0d ready_o=%0d res_o=%h",
                     n, bus.valid_i, bus.ready_i, bus.flush_i, bus.res_i,
                     bus.valid_o, bus.ready_o, bus.res_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
